// File: rtl/rv32_pkg.sv
// Shared RV32 register-file constants and the write-request record used by the
// writeback path.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Small synchronous FIFO buffering long-latency register writes until the
// register-file write port is free.
module rf_wr_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Merges the in-order WB write and buffered long-latency results onto the single
// register-file write port, with anti-starvation drain and a busy scoreboard.
module rf_write_arbiter
    import rv32_pkg::*;
#(
    parameter int XLEN       = rv32_pkg::XLEN,
    parameter int AW         = rv32_pkg::AW,
    parameter int NREG       = rv32_pkg::NREG,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_we,
    input  logic [AW-1:0]   pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    input  logic            lu_valid,
    output logic            lu_ready,
    input  logic [AW-1:0]   lu_rd,
    input  logic [XLEN-1:0] lu_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic [NREG-1:0] busy_mask,
    output logic            stall_req,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            fifo_full,
    output logic            fifo_empty
);

    localparam int SW = $clog2(STARVE_MAX) + 1;
    localparam int EW = AW + XLEN;

    logic            push, pop, drain, wb_grant;
    logic [EW-1:0]   head;
    logic [AW-1:0]   head_rd;
    logic [XLEN-1:0] head_data;
    logic [SW-1:0]   starve_cnt, starve_nxt;
    logic [NREG-1:0] busy_nxt;

    rf_wr_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({lu_rd, lu_data}),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_rd, head_data} = head;
    assign lu_ready = !fifo_full;
    // x0 results still handshake but never occupy a FIFO slot.
    assign push     = lu_valid && lu_ready && (lu_rd != '0);
    assign drain    = stall_req && !fifo_empty;
    assign wb_grant = pipe_we && (pipe_rd != '0) && !drain;
    assign pop      = !fifo_empty && !wb_grant;

    always_comb begin
        starve_nxt = starve_cnt;
        if (pop || fifo_empty)
            starve_nxt = '0;
        else if (wb_grant)
            starve_nxt = starve_cnt + SW'(1);
    end

    // A new issue to the same register outranks the retiring write.
    always_comb begin
        busy_nxt = busy_mask;
        if (pop)
            busy_nxt[head_rd] = 1'b0;
        if (issue_valid && (issue_rd != '0))
            busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            stall_req  <= 1'b0;
            starve_cnt <= '0;
            busy_mask  <= '0;
        end else begin
            rf_we <= wb_grant || pop;
            if (wb_grant) begin
                rf_waddr <= pipe_rd;
                rf_wdata <= pipe_data;
            end else if (pop) begin
                rf_waddr <= head_rd;
                rf_wdata <= head_data;
            end
            stall_req  <= (starve_nxt == SW'(STARVE_MAX - 1));
            starve_cnt <= starve_nxt;
            busy_mask  <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench: expected rf writes are queued as stimulus is driven and
// popped by a negedge monitor; status outputs are checked inline.
module tb_rf_write_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic            clk, rst;
    logic            pipe_we;
    logic [AW-1:0]   pipe_rd;
    logic [XLEN-1:0] pipe_data;
    logic            lu_valid, lu_ready;
    logic [AW-1:0]   lu_rd;
    logic [XLEN-1:0] lu_data;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic [NREG-1:0] busy_mask;
    logic            stall_req, rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            fifo_full, fifo_empty;

    int checks   = 0;
    int failures = 0;
    logic [AW+XLEN-1:0] exp_q [$];

    rf_write_arbiter #(.XLEN(XLEN), .AW(AW), .NREG(NREG), .FIFO_DEPTH(4), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy_mask(busy_mask), .stall_req(stall_req),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // Scoreboard: every rf write must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && rf_we) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL rf_write_unexpected observed=%0h_%0h expected=none", rf_waddr, rf_wdata);
            end
            if (exp_q.size() != 0) begin
                logic [AW+XLEN-1:0] e;
                e = exp_q.pop_front();
                assert ({rf_waddr, rf_wdata} === e) else begin
                    failures++;
                    $error("FAIL rf_write observed=%0h_%0h expected=%0h_%0h",
                           rf_waddr, rf_wdata, e[AW+XLEN-1:XLEN], e[XLEN-1:0]);
                end
            end
        end
    end

    // WB must stay quiet while a forced drain is in progress.
    always @(negedge clk) begin
        if (!rst && stall_req) begin
            checks++;
            assert (!pipe_we) else begin
                failures++;
                $error("FAIL protocol_pipe_we_in_stall observed=1 expected=0");
            end
        end
    end

    initial begin
        rst = 1'b1;
        pipe_we = 0; pipe_rd = '0; pipe_data = '0;
        lu_valid = 0; lu_rd = '0; lu_data = '0;
        issue_valid = 0; issue_rd = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset / idle state
        check("rst_rf_we", rf_we, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_busy", busy_mask, 0);
        check("rst_lu_ready", lu_ready, 1);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_stall", stall_req, 0);

        // WB write, then WB write to x0
        pipe_we = 1; pipe_rd = 5; pipe_data = 32'hDEADBEEF;
        expect_wr(5, 32'hDEADBEEF);
        tick();
        check("wb_we", rf_we, 1);
        check("wb_addr", rf_waddr, 5);
        check("wb_data", rf_wdata, 32'hDEADBEEF);
        pipe_rd = 0; pipe_data = 32'h11111111;
        tick();
        check("wb_x0_we", rf_we, 0);
        pipe_we = 0;
        tick();

        // Busy bit tracks an outstanding long-latency write to x7
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 0;
        check("busy7_set", busy_mask[7], 1);
        tick();
        lu_valid = 1; lu_rd = 7; lu_data = 32'h1234;
        expect_wr(7, 32'h1234);
        tick();
        lu_valid = 0;
        check("lu_enq_busy7", busy_mask[7], 1);
        check("lu_enq_notempty", fifo_empty, 0);
        check("lu_no_bypass", rf_we, 0);
        tick();
        check("lu_pop_we", rf_we, 1);
        check("lu_pop_addr", rf_waddr, 7);
        check("busy7_clear", busy_mask[7], 0);
        tick();

        // lu result to x0: accepted but never queued or written
        check("x0_ready", lu_ready, 1);
        lu_valid = 1; lu_rd = 0; lu_data = 32'hBAD0BAD0;
        tick();
        lu_valid = 0;
        check("x0_empty", fifo_empty, 1);
        tick();
        check("x0_no_we", rf_we, 0);

        // Set beats clear when issue and pop target x9 together
        issue_valid = 1; issue_rd = 9;
        tick();
        issue_valid = 0;
        lu_valid = 1; lu_rd = 9; lu_data = 32'h99;
        expect_wr(9, 32'h99);
        tick();
        lu_valid = 0;
        issue_valid = 1; issue_rd = 9;
        tick();
        issue_valid = 0;
        check("setclr_addr", rf_waddr, 9);
        check("setclr_busy9", busy_mask[9], 1);
        lu_valid = 1; lu_rd = 9; lu_data = 32'h9A;
        expect_wr(9, 32'h9A);
        tick();
        lu_valid = 0;
        check("busy9_held", busy_mask[9], 1);
        tick();
        check("busy9_clear", busy_mask[9], 0);
        tick();

        // Starvation: WB every cycle while four lu results fill the FIFO
        for (int i = 0; i < 4; i++) begin
            pipe_we = 1; pipe_rd = AW'(10 + i); pipe_data = 32'hA000 + i;
            lu_valid = 1; lu_rd = AW'(16 + i); lu_data = 32'hB000 + i;
            expect_wr(AW'(10 + i), 32'hA000 + i);
            tick();
            if (i == 2) check("starve_no_stall_yet", stall_req, 0);
        end
        pipe_we = 0; lu_valid = 0;
        check("starve_full", fifo_full, 1);
        check("starve_lu_ready", lu_ready, 0);
        check("starve_stall", stall_req, 1);
        for (int i = 0; i < 4; i++) expect_wr(AW'(16 + i), 32'hB000 + i);
        tick();
        check("drain_stall_pulse", stall_req, 0);
        check("drain_addr", rf_waddr, 16);
        check("drain_not_full", fifo_full, 0);
        tick(); tick(); tick();
        check("drain_empty", fifo_empty, 1);
        tick();
        check("drain_idle_we", rf_we, 0);

        // Reset with three entries queued and busy bits outstanding
        for (int i = 0; i < 3; i++) begin
            pipe_we = 1; pipe_rd = 20; pipe_data = 32'hC000 + i;
            lu_valid = 1; lu_rd = AW'(21 + i); lu_data = 32'hD000 + i;
            issue_valid = 1; issue_rd = AW'(21 + i);
            expect_wr(20, 32'hC000 + i);
            tick();
        end
        pipe_we = 0; lu_valid = 0; issue_valid = 0;
        check("burst_busy", busy_mask, 32'h00E0_0000);
        check("burst_notempty", fifo_empty, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_empty", fifo_empty, 1);
        check("midrst_busy", busy_mask, 0);
        check("midrst_we", rf_we, 0);
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        check("postrst_empty", fifo_empty, 1);
        check("postrst_we", rf_we, 0);
        check("postrst_ready", lu_ready, 1);

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
